branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Parametrised branch target buffer with per-entry saturating direction counters, for the IF stage of the 5-stage pipelined MIPS CPU. The current datapath resolves branches and jumps late in the pipeline with no prediction. This block gives a same-cycle next-PC prediction from the fetch PC. It is trained by the resolved branch/jump outcome from the stage that resolves control flow, and it reports mispredictions and a redirect PC so the pipeline can flush.

## Interface
Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- ADDR_W, 32, PC width.
- CTR_W, 2, direction-counter width, ≥1.
- STAT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_IF  in  ADDR_W  current fetch PC.
- pred_hit  out  1  pc_IF hits a valid entry with a matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted next PC.
- upd_valid  in  1  a resolved branch/jump is presented this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_taken  in  1  actual outcome; must be 1 when upd_is_jump=1.
- upd_target  in  ADDR_W  actual taken target.
- upd_is_jump  in  1  instruction is J/JAL.
- upd_pred_taken  in  1  pred_taken carried down the pipeline with the instruction.
- upd_pred_target  in  ADDR_W  pred_target carried with the instruction.
- flush_all  in  1  invalidate every entry.
- mispredict  out  1  resolved outcome differs from the carried prediction.
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1.
- stat_updates  out  STAT_W  saturating count of upd_valid cycles.
- stat_mispredicts  out  STAT_W  saturating count of mispredict cycles.

## Operation
- IDX_W = log2(ENTRIES). Index = pc[IDX_W+1:2]. Tag = pc[ADDR_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag, target[ADDR_W], ctr[CTR_W], jump flag.
- Lookup is combinational from the stored table:
  - hit = valid && tag match.
  - pred_taken = hit && (jump flag || ctr MSB).
  - pred_target = pred_taken ? entry target : pc_IF+4, where +4 wraps modulo 2^ADDR_W.
- mispredict is combinational: upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. redirect_pc is valid only when mispredict=1.
- Update on the clock edge when upd_valid=1, at the index of upd_pc:
  - Tag hit, branch: ctr increments if taken, decrements if not, saturating at 0 and 2^CTR_W−1. If taken, target is rewritten.
  - Tag hit, jump: jump flag is set, ctr is set to max, target is rewritten.
  - Miss and taken: allocate by overwriting the entry (no replacement policy beyond direct mapping). valid=1, new tag, target=upd_target, jump flag=upd_is_jump. ctr = max for a jump, otherwise weakly taken (1<<(CTR_W−1)).
  - Miss and not taken: table unchanged.
- flush_all clears every valid bit at the edge. It takes priority over a simultaneous update, so the update is dropped.
- Statistics:
  - stat_updates increments on each upd_valid cycle.
  - stat_mispredicts increments on each mispredict cycle.
  - Both saturate at all-ones. flush_all does not clear them.

## Timing
- Lookup has zero latency: the prediction is valid in the same cycle as pc_IF.
- Update has a write latency of 1. An update presented in cycle N is visible to lookups from cycle N+1.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents.
- Reset:
  - On a rst edge, all valid bits, ctr values and statistics clear to 0.
  - While rst=1: pred_hit=0, pred_taken=0, pred_target=pc_IF+4, mispredict=0. Updates are ignored.
  - Reset mid-operation discards any in-flight update.
- Reset values of the outputs after reset: stat_updates=0, stat_mispredicts=0, pred_hit=0.

## Test plan
- Cold lookup: rst for 2 cycles, then pc_IF=0x0040_0010 → pred_hit=0, pred_taken=0, pred_target=0x0040_0014; stats=0.
- Allocate: upd pc=0x0040_0010, taken, target=0x0040_0040, upd_pred_taken=0 → mispredict=1, redirect_pc=0x0040_0040. Next cycle, pc_IF=0x0040_0010 → hit=1, taken=1, target=0x0040_0040; stat_mispredicts=1, stat_updates=1.
- Counter hysteresis and saturation (CTR_W=2):
  - From ctr=2, not-taken update → ctr=1, pred_taken=0.
  - Two further not-taken updates → ctr stays 0.
  - Four taken updates → ctr=3, pred_taken=1.
  - A single not-taken update then keeps pred_taken=1.
- Aliasing: with the entry from the allocate scenario, pc_IF=0x0040_0050 (same index 4, different tag) → hit=0. Taken update at 0x0040_0050 to 0x0040_0100 → 0x0040_0050 now hits, and 0x0040_0010 misses.
- Jump: update pc=0x0040_0020, is_jump=1, target=0x0040_1000 → subsequent lookup taken. Three not-taken-style counter decrements are not applicable, and the prediction stays taken.
- Same-cycle read/write plus flush/reset:
  - Update and lookup of 0x0040_0030 in the same cycle → lookup shows a miss, and a hit on the next cycle.
  - flush_all together with upd_valid → all lookups miss and the update is dropped. stat_updates still increments.
  - rst mid-stream → stats=0.
- Stat saturation: with STAT_W=4, drive 20 mispredicting updates → stat_mispredicts=15, stat_updates=15.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch-side prediction / resolve-side training bus of the branch target predictor.
//   master: drives fetch PC, resolved branch/jump update, flush_all;
//           observes prediction, mispredict/redirect and statistics.
//   slave : the predictor itself.
interface branch_target_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
) ();
    logic [ADDR_W-1:0] pc_IF;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_is_jump;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_target;
    logic              flush_all;
    logic              mispredict;
    logic [ADDR_W-1:0] redirect_pc;
    logic [STAT_W-1:0] stat_updates;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output pc_IF, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, flush_all,
        input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               stat_updates, stat_mispredicts
    );

    modport slave (
        input  pc_IF, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, flush_all,
        output pred_hit, pred_taken, pred_target, mispredict, redirect_pc,
               stat_updates, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of branch_target_predictor_if
//              lookup  : pc_IF -> pred_hit / pred_taken / pred_target (combinational)
//              training: upd_* resolved outcome, written at the clock edge
//              control : flush_all invalidates all entries
//              status  : mispredict / redirect_pc (combinational), saturating stats
module branch_target_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_target_predictor_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]  CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jump_q, jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];
    logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
    logic [STAT_W-1:0]  stat_mis_q, stat_mis_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, lk_taken, up_hit, mispredict;

    assign lk_idx = bus.pc_IF[IDX_W+1:2];
    assign lk_tag = bus.pc_IF[ADDR_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    always_comb begin
        lk_hit   = ~rst & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit & (jump_q[lk_idx] | ctr_q[lk_idx][CTR_W-1]);
        up_hit   = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
        mispredict = ~rst & bus.upd_valid &
                     ((bus.upd_pred_taken != bus.upd_taken) |
                      (bus.upd_taken & (bus.upd_pred_target != bus.upd_target)));
    end

    assign bus.pred_hit         = lk_hit;
    assign bus.pred_taken       = lk_taken;
    assign bus.pred_target      = lk_taken ? target_q[lk_idx] : bus.pc_IF + PC_STEP;
    assign bus.mispredict       = mispredict;
    assign bus.redirect_pc      = bus.upd_taken ? bus.upd_target : bus.upd_pc + PC_STEP;
    assign bus.stat_updates     = stat_upd_q;
    assign bus.stat_mispredicts = stat_mis_q;

    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;

        // Flush wins over a simultaneous update; the update is dropped.
        if (bus.flush_all) begin
            valid_d = '0;
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_is_jump) begin
                    jump_d[up_idx]   = 1'b1;
                    ctr_d[up_idx]    = CTR_MAX;
                    target_d[up_idx] = bus.upd_target;
                end else if (bus.upd_taken) begin
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
                    end
                    target_d[up_idx] = bus.upd_target;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (bus.upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                jump_d[up_idx]   = bus.upd_is_jump;
                ctr_d[up_idx]    = bus.upd_is_jump ? CTR_MAX : CTR_WEAK;
            end
        end

        stat_upd_d = stat_upd_q;
        stat_mis_d = stat_mis_q;
        if (bus.upd_valid && stat_upd_q != STAT_MAX) begin
            stat_upd_d = stat_upd_q + STAT_W'(1);
        end
        if (mispredict && stat_mis_q != STAT_MAX) begin
            stat_mis_d = stat_mis_q + STAT_W'(1);
        end
    end

    // Tags and targets are don't-care while invalid, so they are not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            jump_q     <= '0;
            stat_upd_q <= '0;
            stat_mis_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            jump_q     <= jump_d;
            stat_upd_q <= stat_upd_d;
            stat_mis_q <= stat_mis_d;
            tag_q      <= tag_d;
            target_q   <= target_d;
            ctr_q      <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
module tb_branch_target_predictor;
    localparam int ENTRIES  = 16;
    localparam int CTR_MAX  = 3;
    localparam int CTR_HALF = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_target_predictor_if #(.ADDR_W(32), .STAT_W(16)) bus ();
    branch_target_predictor_if #(.ADDR_W(32), .STAT_W(4))  bus4 ();

    assign bus4.pc_IF           = bus.pc_IF;
    assign bus4.upd_valid       = bus.upd_valid;
    assign bus4.upd_pc          = bus.upd_pc;
    assign bus4.upd_taken       = bus.upd_taken;
    assign bus4.upd_target      = bus.upd_target;
    assign bus4.upd_is_jump     = bus.upd_is_jump;
    assign bus4.upd_pred_taken  = bus.upd_pred_taken;
    assign bus4.upd_pred_target = bus.upd_pred_target;
    assign bus4.flush_all       = bus.flush_all;

    branch_target_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    branch_target_predictor #(.ENTRIES(16), .ADDR_W(32), .CTR_W(2), .STAT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference table: entry i covers pcs with (pc/4) mod ENTRIES == i.
    bit          m_valid [ENTRIES];
    bit          m_jump  [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_nupd = 0;
    int          m_nmis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic predict(input logic [31:0] pc, output bit hit, output bit tk,
                           output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        hit = !rst && m_valid[i] && m_tag[i] == tag_of(pc);
        tk  = hit && (m_jump[i] || m_ctr[i] >= CTR_HALF);
        tgt = tk ? m_tgt[i] : pc + 32'd4;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic jmp, input logic ptk, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_is_jump     = jmp;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic idle();
        bus.upd_valid = 1'b0;
        bus.flush_all = 1'b0;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model at the
    // edge, then check the registered statistics just after it.
    task automatic tick();
        bit hit, tk, mis;
        logic [31:0] tgt, rd;
        int ui;
        @(negedge clk);
        predict(bus.pc_IF, hit, tk, tgt);
        chk("pred_hit", bus.pred_hit, hit);
        chk("pred_taken", bus.pred_taken, tk);
        chk("pred_target", bus.pred_target, tgt);
        chk("pred_hit_s4", bus4.pred_hit, hit);
        mis = !rst && bus.upd_valid &&
              (bus.upd_pred_taken != bus.upd_taken ||
               (bus.upd_taken && bus.upd_pred_target != bus.upd_target));
        rd = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
        chk("mispredict", bus.mispredict, mis);
        if (mis) chk("redirect_pc", bus.redirect_pc, rd);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = 0;
            end
            m_nupd = 0;
            m_nmis = 0;
        end else begin
            if (bus.upd_valid) m_nupd++;
            if (mis) m_nmis++;
            if (bus.flush_all) begin
                for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
            end else if (bus.upd_valid) begin
                ui = idx_of(bus.upd_pc);
                if (m_valid[ui] && m_tag[ui] == tag_of(bus.upd_pc)) begin
                    if (bus.upd_is_jump) begin
                        m_jump[ui] = 1;
                        m_ctr[ui]  = CTR_MAX;
                        m_tgt[ui]  = bus.upd_target;
                    end else if (bus.upd_taken) begin
                        m_ctr[ui] = (m_ctr[ui] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[ui] + 1;
                        m_tgt[ui] = bus.upd_target;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    end
                end else if (bus.upd_taken) begin
                    m_valid[ui] = 1;
                    m_tag[ui]   = tag_of(bus.upd_pc);
                    m_tgt[ui]   = bus.upd_target;
                    m_jump[ui]  = bus.upd_is_jump;
                    m_ctr[ui]   = bus.upd_is_jump ? CTR_MAX : CTR_HALF;
                end
            end
        end
        #1;
        chk("stat_updates", bus.stat_updates, sat(m_nupd, 65535));
        chk("stat_mispredicts", bus.stat_mispredicts, sat(m_nmis, 65535));
        chk("stat_updates_s4", bus4.stat_updates, sat(m_nupd, 15));
        chk("stat_mispredicts_s4", bus4.stat_mispredicts, sat(m_nmis, 15));
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        base = ($urandom_range(0, 1) == 0) ? 32'h0040_0000 : 32'h0040_0400;
        return base + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        bit hit, tk;
        logic [31:0] tgt;
        logic [31:0] pcs [5];

        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_jump[i] = 0; m_ctr[i] = 0;
            m_tag[i] = '0; m_tgt[i] = '0;
        end
        bus.pc_IF = 32'h0040_0010;
        set_upd(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        idle();

        // Cold lookup after a two-cycle reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #2;
        chk("cold_hit", bus.pred_hit, 32'd0);
        chk("cold_taken", bus.pred_taken, 32'd0);
        chk("cold_target", bus.pred_target, 32'h0040_0014);
        chk("cold_stat_upd", bus.stat_updates, 32'd0);
        chk("cold_stat_mis", bus.stat_mispredicts, 32'd0);
        tick();

        // Allocate on a taken miss
        set_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0014);
        #2;
        chk("alloc_mispredict", bus.mispredict, 32'd1);
        chk("alloc_redirect", bus.redirect_pc, 32'h0040_0040);
        tick();
        idle();
        #2;
        chk("alloc_hit", bus.pred_hit, 32'd1);
        chk("alloc_taken", bus.pred_taken, 32'd1);
        chk("alloc_target", bus.pred_target, 32'h0040_0040);
        chk("alloc_stat_mis", bus.stat_mispredicts, 32'd1);
        chk("alloc_stat_upd", bus.stat_updates, 32'd1);
        tick();

        // Counter hysteresis and saturation
        set_upd(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 1'b1, 32'h0040_0040);
        tick();
        idle();
        #2;
        chk("ctr1_taken", bus.pred_taken, 32'd0);
        set_upd(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0014);
        tick();
        tick();
        set_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0014);
        tick();
        idle();
        #2;
        chk("ctr_from0_taken", bus.pred_taken, 32'd0);
        set_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0014);
        for (int i = 0; i < 3; i++) tick();
        idle();
        #2;
        chk("ctr3_taken", bus.pred_taken, 32'd1);
        set_upd(32'h0040_0010, 1'b0, 32'h0040_0040, 1'b0, 1'b1, 32'h0040_0040);
        tick();
        idle();
        #2;
        chk("ctr_hyst_taken", bus.pred_taken, 32'd1);
        tick();

        // Aliasing at index 4
        bus.pc_IF = 32'h0040_0050;
        #2;
        chk("alias_miss", bus.pred_hit, 32'd0);
        set_upd(32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0054);
        tick();
        idle();
        #2;
        chk("alias_new_hit", bus.pred_hit, 32'd1);
        chk("alias_new_target", bus.pred_target, 32'h0040_0100);
        bus.pc_IF = 32'h0040_0010;
        #2;
        chk("alias_old_miss", bus.pred_hit, 32'd0);
        tick();

        // Jump entry stays taken through branch-style decrements
        bus.pc_IF = 32'h0040_0020;
        set_upd(32'h0040_0020, 1'b1, 32'h0040_1000, 1'b1, 1'b0, 32'h0040_0024);
        tick();
        idle();
        #2;
        chk("jump_taken", bus.pred_taken, 32'd1);
        chk("jump_target", bus.pred_target, 32'h0040_1000);
        set_upd(32'h0040_0020, 1'b0, 32'h0040_1000, 1'b0, 1'b1, 32'h0040_1000);
        for (int i = 0; i < 3; i++) tick();
        idle();
        #2;
        chk("jump_still_taken", bus.pred_taken, 32'd1);
        tick();

        // Same-cycle update and lookup return pre-update contents
        bus.pc_IF = 32'h0040_0030;
        set_upd(32'h0040_0030, 1'b1, 32'h0040_0200, 1'b0, 1'b0, 32'h0040_0034);
        #2;
        chk("rw_same_cycle_miss", bus.pred_hit, 32'd0);
        tick();
        idle();
        #2;
        chk("rw_next_cycle_hit", bus.pred_hit, 32'd1);
        tick();

        // Flush together with an update
        set_upd(32'h0040_0070, 1'b1, 32'h0040_0300, 1'b0, 1'b0, 32'h0040_0074);
        bus.flush_all = 1'b1;
        tick();
        idle();
        pcs[0] = 32'h0040_0010; pcs[1] = 32'h0040_0020; pcs[2] = 32'h0040_0030;
        pcs[3] = 32'h0040_0050; pcs[4] = 32'h0040_0070;
        for (int i = 0; i < 5; i++) begin
            bus.pc_IF = pcs[i];
            #2;
            chk("flush_miss", bus.pred_hit, 32'd0);
        end
        tick();

        // Reset mid-stream discards the in-flight update and clears stats
        set_upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0014);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        #2;
        chk("rst_stat_upd", bus.stat_updates, 32'd0);
        chk("rst_stat_mis", bus.stat_mispredicts, 32'd0);
        bus.pc_IF = 32'h0040_0010;
        #2;
        chk("rst_dropped_upd", bus.pred_hit, 32'd0);
        tick();

        // Randomised traffic against the reference table
        for (int n = 0; n < 500; n++) begin
            rst           = ($urandom_range(0, 99) == 0);
            bus.flush_all = ($urandom_range(0, 49) == 0);
            bus.pc_IF     = rand_pc();
            bus.upd_valid   = $urandom_range(0, 1);
            bus.upd_pc      = rand_pc();
            bus.upd_is_jump = ($urandom_range(0, 5) == 0);
            bus.upd_taken   = bus.upd_is_jump | 1'($urandom_range(0, 1));
            bus.upd_target  = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 3) != 0) begin
                predict(bus.upd_pc, hit, tk, tgt);
                bus.upd_pred_taken  = tk;
                bus.upd_pred_target = tgt;
            end else begin
                bus.upd_pred_taken  = 1'($urandom_range(0, 1));
                bus.upd_pred_target = 32'h0040_0000 + 32'($urandom_range(0, 255)) * 4;
            end
            tick();
        end
        rst = 1'b0;
        idle();

        // Statistics saturation on the 4-bit instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            set_upd(32'h0040_0800 + 32'(n) * 4, 1'b1, 32'h0040_0900, 1'b0, 1'b0, 32'h0);
            tick();
        end
        idle();
        #2;
        chk("sat_stat_mis_s4", bus4.stat_mispredicts, 32'd15);
        chk("sat_stat_upd_s4", bus4.stat_updates, 32'd15);
        chk("sat_stat_mis_w16", bus.stat_mispredicts, 32'd20);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
